// File: rtl/fft_input_loader_if.sv
// ============================================================================
//  Module      : fft_input_loader_if
//  Description : Bundle of the streaming sample input and the bit-reversed
//                frame output of the FFT input loader.
//                master : sample source / frame consumer side
//                slave  : the loader itself
//  Signals     : s_data/s_valid/s_last/s_ready  - time-domain sample stream
//                frame_data/frame_valid/frame_ready - 32-point frame handoff
//                sync_err    - one-cycle pulse on s_last misalignment
//                frame_count - frames consumed downstream (mod 256)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_input_loader_if #(
    parameter int DW = 8
);
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [32*2*DW-1:0]   frame_data;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 sync_err;
    logic [7:0]           frame_count;

    modport master (
        output s_data, s_valid, s_last, frame_ready,
        input  s_ready, frame_data, frame_valid, sync_err, frame_count
    );

    modport slave (
        input  s_data, s_valid, s_last, frame_ready,
        output s_ready, frame_data, frame_valid, sync_err, frame_count
    );
endinterface

`default_nettype wire

// File: rtl/fft_input_loader.sv
// ============================================================================
//  Module      : fft_input_loader
//  Description : Collects 32 real samples per frame into a ping-pong pair of
//                banks, storing each sample at its bit-reversed address so
//                the full bank presents a radix-2 DIT ready frame. Imaginary
//                halves are zero.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - fft_input_loader_if.slave (sample in, frame out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_input_loader #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    fft_input_loader_if.slave  bus
);

    localparam int c_N = 32;

    logic [DW-1:0] bank_q [2][c_N];
    logic [4:0]    wr_cnt_q,      wr_cnt_d;
    logic          wr_sel_q,      wr_sel_d;
    logic          rd_sel_q,      rd_sel_d;
    logic [1:0]    full_q,        full_d;
    logic          sync_err_q,    sync_err_d;
    logic [7:0]    frame_count_q, frame_count_d;

    logic          w_accept;
    logic          w_consume;
    logic          w_last_slot;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    assign bus.s_ready     = !rst && !full_q[wr_sel_q];
    assign w_accept        = bus.s_valid && bus.s_ready;
    assign w_consume       = full_q[rd_sel_q] && bus.frame_ready;
    assign w_last_slot     = (wr_cnt_q == 5'd31);

    assign bus.frame_valid = full_q[rd_sel_q];
    assign bus.sync_err    = sync_err_q;
    assign bus.frame_count = frame_count_q;

    // Bank words are already in bit-reversed order, so word j maps straight
    // onto output word j.
    generate
        for (genvar j = 0; j < c_N; j++) begin : g_word
            assign bus.frame_data[2*DW*j +: 2*DW] = {bank_q[rd_sel_q][j], {DW{1'b0}}};
        end
    endgenerate

    // Completion and consumption always target different banks: completion
    // needs full[wr_sel]=0, consumption needs full[rd_sel]=1, so both may
    // update full_d in the same cycle without conflict.
    always_comb begin
        full_d        = full_q;
        wr_cnt_d      = wr_cnt_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        sync_err_d    = 1'b0;
        frame_count_d = frame_count_q;

        if (w_accept) begin
            if (w_last_slot) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
                wr_cnt_d         = 5'd0;
                sync_err_d       = !bus.s_last;
            end else if (bus.s_last) begin
                // Early s_last: drop the partial frame and resynchronise.
                wr_cnt_d   = 5'd0;
                sync_err_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 5'd1;
            end
        end

        if (w_consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            frame_count_d    = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q      <= 5'd0;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            full_q        <= 2'b00;
            sync_err_q    <= 1'b0;
            frame_count_q <= 8'd0;
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < c_N; w++) begin
                    bank_q[b][w] <= '0;
                end
            end
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            full_q        <= full_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
            if (w_accept) begin
                bank_q[wr_sel_q][bitrev5(wr_cnt_q)] <= bus.s_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_input_loader.sv
// ============================================================================
//  Module      : tb_fft_input_loader
//  Description : Self-checking bench for fft_input_loader. A negedge monitor
//                keeps a frame-level reference model (queue of pending
//                frames, list of collected samples) and compares every
//                DUT output each cycle; stimulus runs in a separate process.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_input_loader;

    localparam int DW   = 8;
    localparam int c_FW = 32*2*DW;
    typedef logic [c_FW-1:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_input_loader_if #(.DW(DW)) bus_if ();

    fft_input_loader #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    frame_t        exp_q[$];     // complete frames awaiting consumption
    logic [DW-1:0] part_q[$];    // samples of the frame being collected
    logic          exp_sync  = 1'b0;
    int            consumed  = 0;
    bit            chk_zero  = 1'b1;
    bit            rand_fr   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) if (v[b]) r |= 1 << (4 - b);
        return r;
    endfunction

    task automatic check(input string name, input frame_t got, input frame_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        frame_t f;
        bit     have_frame;
        f          = '0;
        have_frame = 1'b0;

        check("s_ready",     frame_t'(bus_if.s_ready),     frame_t'(!rst && (exp_q.size() < 2)));
        check("frame_valid", frame_t'(bus_if.frame_valid), frame_t'(exp_q.size() != 0));
        check("sync_err",    frame_t'(bus_if.sync_err),    frame_t'(exp_sync));
        check("frame_count", frame_t'(bus_if.frame_count), frame_t'(consumed % 256));
        if (exp_q.size() != 0)
            check("frame_data", bus_if.frame_data, exp_q[0]);
        else if (chk_zero)
            check("frame_data_reset", bus_if.frame_data, '0);

        // Predict the effect of the coming rising edge.
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            exp_sync = 1'b0;
            consumed = 0;
            chk_zero = 1'b1;
        end else begin
            chk_zero = 1'b0;
            exp_sync = 1'b0;
            if (bus_if.s_valid && exp_q.size() < 2) begin
                part_q.push_back(bus_if.s_data);
                if (part_q.size() == 32) begin
                    for (int i = 0; i < 32; i++)
                        f[bitrev(i)*2*DW +: 2*DW] = {part_q[i], {DW{1'b0}}};
                    have_frame = 1'b1;
                    exp_sync   = !bus_if.s_last;
                    part_q.delete();
                end else if (bus_if.s_last) begin
                    exp_sync = 1'b1;
                    part_q.delete();
                end
            end
            if (exp_q.size() != 0 && bus_if.frame_ready) begin
                void'(exp_q.pop_front());
                consumed++;
            end
            if (have_frame) exp_q.push_back(f);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_fr) bus_if.frame_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int   budget;
        logic acc;
        budget = 0;
        acc    = 1'b0;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = d;
        bus_if.s_last  = last;
        forever begin
            @(negedge clk);
            acc = bus_if.s_ready;
            step();
            if (acc) break;
            budget++;
            if (budget > 1000) begin
                check("accept_timeout", frame_t'(acc), frame_t'(1));
                break;
            end
        end
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    // Sends n beats; s_last on beat index last_at (-1 for none).
    task automatic send_beats(input int n, input bit ramp, input bit gaps, input int last_at);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = ramp ? DW'(i) : DW'($urandom_range(0, 255));
            send_beat(d, i == last_at);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0) begin
            step();
            budget++;
            if (budget > 2000) begin
                check("drain_timeout", frame_t'(exp_q.size()), frame_t'(0));
                break;
            end
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int r;
        int len;
        bus_if.s_valid     = 1'b0;
        bus_if.s_data      = '0;
        bus_if.s_last      = 1'b0;
        bus_if.frame_ready = 1'b0;
        idle(3);
        rst = 1'b0;

        // Ramp frame with downstream always ready.
        bus_if.frame_ready = 1'b1;
        send_beats(32, 1'b1, 1'b0, 31);
        drain();

        // Backpressure: two frames buffered, third held off.
        bus_if.frame_ready = 1'b0;
        send_beats(32, 1'b0, 1'b0, 31);
        send_beats(32, 1'b0, 1'b0, 31);
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 8'hA5;
        idle(4);
        bus_if.frame_ready = 1'b1;
        send_beats(32, 1'b0, 1'b0, 31);
        drain();

        // Misalignment: early s_last, clean frame, missing s_last.
        send_beats(11, 1'b0, 1'b0, 10);
        send_beats(32, 1'b0, 1'b0, 31);
        send_beats(32, 1'b0, 1'b0, -1);
        drain();

        // Completion into one bank while the other is consumed.
        bus_if.frame_ready = 1'b0;
        send_beats(32, 1'b0, 1'b0, 31);
        send_beats(31, 1'b0, 1'b0, -1);
        bus_if.frame_ready = 1'b1;
        send_beats(1, 1'b0, 1'b0, 0);
        send_beats(32, 1'b0, 1'b0, 31);
        drain();

        // Randomised traffic with random downstream readiness.
        rand_fr = 1'b1;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_beats(32, 1'b0, 1'b1, -1);
            end else if (r == 1) begin
                len = $urandom_range(1, 31);
                send_beats(len, 1'b0, 1'b1, len - 1);
            end else begin
                send_beats(32, 1'b0, 1'b1, 31);
            end
        end
        rand_fr = 1'b0;
        bus_if.frame_ready = 1'b1;
        drain();

        // Reset with one frame pending and a partial frame in progress.
        bus_if.frame_ready = 1'b0;
        send_beats(32, 1'b0, 1'b0, 31);
        send_beats(20, 1'b0, 1'b0, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus_if.frame_ready = 1'b1;
        send_beats(32, 1'b1, 1'b0, 31);

        // Frame counter wrap: 256 consumes since reset.
        for (int k = 0; k < 255; k++) send_beats(32, 1'b0, 1'b0, 31);
        drain();
        step();
        check("wrap_count", frame_t'(bus_if.frame_count), frame_t'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
